// File: rtl/screen_scanner.sv
// Frame-buffer scanner: walks the video RAM one 16-bit word at a time and
// serialises each word LSB-first onto a valid/ready pixel stream, with
// start-of-frame, end-of-line and frame-done markers.
module screen_scanner #(
  parameter int SCREEN_BASE    = 16384,
  parameter int WORDS_PER_LINE = 32,
  parameter int LINES          = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [14:0] addressV,
  input  logic [15:0] outV,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done
);

  localparam int FRAME_WORDS = WORDS_PER_LINE * LINES;
  localparam int IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int COL_W       = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [14:0]      BASE_A    = 15'(SCREEN_BASE);
  localparam logic [14:0]      ADDR_LAST = 15'(SCREEN_BASE + FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_WORDS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t           state_q;
  logic [15:0]      sh_q;
  logic [3:0]       bit_cnt_q;
  logic [IDX_W-1:0] word_idx_q;
  // Column of the word in sh_q within its line; avoids a modulo on word_idx_q.
  logic [COL_W-1:0] col_q;
  logic             stop_q;
  logic [14:0]      addr_q;
  logic             frame_done_q;

  logic run;
  logic hs;

  // Next read address, wrapping inside the frame window so the RAM never
  // sees an address past the last screen word.
  function automatic logic [14:0] addr_inc(input logic [14:0] a);
    return (a == ADDR_LAST) ? BASE_A : a + 15'd1;
  endfunction

  assign run = (state_q == RUN);
  assign hs  = run & pix_ready;

  // Scanner FSM: address generation, word capture and per-pixel shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sh_q         <= 16'd0;
      bit_cnt_q    <= 4'd0;
      word_idx_q   <= '0;
      col_q        <= '0;
      stop_q       <= 1'b0;
      addr_q       <= BASE_A;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= BASE_A;
          stop_q <= 1'b0;
          if (enable) state_q <= PRIME;
        end
        PRIME: begin
          // RAM is already presenting word 0; grab it and point at word 1.
          sh_q       <= outV;
          bit_cnt_q  <= 4'd0;
          word_idx_q <= '0;
          col_q      <= '0;
          addr_q     <= addr_inc(BASE_A);
          if (!enable) stop_q <= 1'b1;
          state_q    <= RUN;
        end
        RUN: begin
          if (!enable) stop_q <= 1'b1;
          if (hs) begin
            if (bit_cnt_q != 4'd15) begin
              sh_q      <= {1'b0, sh_q[15:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (word_idx_q != IDX_LAST) begin
              // addr_q already points at the next word, so load without a bubble.
              sh_q       <= outV;
              bit_cnt_q  <= 4'd0;
              word_idx_q <= word_idx_q + IDX_W'(1);
              col_q      <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
              addr_q     <= addr_inc(addr_q);
            end else begin
              // Last pixel of the frame; addr_q has wrapped back to word 0.
              frame_done_q <= 1'b1;
              bit_cnt_q    <= 4'd0;
              word_idx_q   <= '0;
              col_q        <= '0;
              if (enable && !stop_q) begin
                sh_q   <= outV;
                addr_q <= addr_inc(BASE_A);
              end else begin
                state_q <= IDLE;
                addr_q  <= BASE_A;
                stop_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= BASE_A;
        end
      endcase
    end
  end

  assign addressV   = addr_q;
  assign pix_valid  = run;
  assign pix_data   = run & sh_q[0];
  assign pix_sof    = run & (word_idx_q == '0) & (bit_cnt_q == 4'd0);
  assign pix_eol    = run & (bit_cnt_q == 4'd15) & (col_q == COL_LAST);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner using a reduced 4x4-word frame so several whole
// frames fit in a short run; the RAM is a combinational array model.
module tb_screen_scanner;

  localparam int BASE = 16384;
  localparam int WPL  = 4;
  localparam int LNS  = 4;
  localparam int FW   = WPL * LNS;
  localparam int NPIX = FW * 16;

  logic        clk = 1'b0;
  logic        rst_n, enable, pix_ready;
  logic [14:0] addressV;
  logic [15:0] outV;
  logic        pix_valid, pix_data, pix_sof, pix_eol, frame_done;

  logic [15:0] ram  [FW];
  logic [15:0] img1 [FW];
  logic [15:0] img2 [FW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  screen_scanner #(.SCREEN_BASE(BASE), .WORDS_PER_LINE(WPL), .LINES(LNS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .addressV(addressV), .outV(outV),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done)
  );

  // Combinational RAM read; out-of-window addresses return a marker value.
  always_comb begin
    outV = 16'hDEAD;
    if (int'(addressV) >= BASE && int'(addressV) < BASE + FW) outV = ram[addressV[3:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {data, sof, eol} for frame-relative pixel k taken from word w.
  function automatic logic [2:0] exp_px(input int k, input logic [15:0] w);
    logic b, s, e;
    b = w[k % 16];
    s = (k == 0);
    e = ((k % 16) == 15) && (((k / 16) % WPL) == WPL - 1);
    return {b, s, e};
  endfunction

  typedef struct {
    logic        rst_n, en, rdy;
    logic        v, d, sof, eol, done;
    logic [14:0] addr;
  } vec_t;

  vec_t tbl [24];

  task automatic setv(input int i, input logic r, input logic e, input logic y,
                      input logic v, input logic d, input logic s, input logic [14:0] a);
    tbl[i].rst_n = r; tbl[i].en = e; tbl[i].rdy = y;
    tbl[i].v = v; tbl[i].d = d; tbl[i].sof = s; tbl[i].eol = 1'b0; tbl[i].done = 1'b0;
    tbl[i].addr = a;
  endtask

  int k, n_eol, n_sof, n_done, bad_addr, gaps, extra_done;
  logic have_stall, started, mod_done, stopped;
  logic [2:0] saved, got;
  logic [15:0] w;

  initial begin
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < FW; i++) ram[i] = 16'h0000;
    ram[0] = 16'h0005;
    ram[1] = 16'hFFFF;

    // Cycle table: reset, prime, first word 0x0005 with one stall, word boundary into 0xFFFF.
    setv(0, 0, 0, 0, 0, 0, 0, 15'd16384);
    setv(1, 0, 1, 1, 0, 0, 0, 15'd16384);
    setv(2, 1, 1, 1, 0, 0, 0, 15'd16384);
    setv(3, 1, 1, 1, 1, 1, 1, 15'd16385);
    setv(4, 1, 1, 1, 1, 0, 0, 15'd16385);
    setv(5, 1, 1, 1, 1, 1, 0, 15'd16385);
    setv(6, 1, 1, 0, 1, 1, 0, 15'd16385);
    setv(7, 1, 1, 1, 1, 0, 0, 15'd16385);
    for (int i = 8; i < 20; i++) setv(i, 1, 1, 1, 1, 0, 0, 15'd16385);
    setv(20, 1, 1, 1, 1, 1, 0, 15'd16386);
    setv(21, 1, 1, 1, 1, 1, 0, 15'd16386);
    setv(22, 1, 0, 1, 1, 1, 0, 15'd16386);
    setv(23, 1, 0, 1, 1, 1, 0, 15'd16386);

    for (int i = 0; i < 24; i++) begin
      rst_n = tbl[i].rst_n; enable = tbl[i].en; pix_ready = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(pix_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_data", i), 32'(pix_data), 32'(tbl[i].d));
      chk($sformatf("vec%0d_sof", i), 32'(pix_sof), 32'(tbl[i].sof));
      chk($sformatf("vec%0d_eol", i), 32'(pix_eol), 32'(tbl[i].eol));
      chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_addr", i), 32'(addressV), 32'(tbl[i].addr));
    end

    // One frame with random back-pressure; enable drops early in the frame.
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < FW; i++) begin ram[i] = 16'($urandom); img1[i] = ram[i]; end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    k = 0; n_eol = 0; n_sof = 0; n_done = 0; bad_addr = 0; have_stall = 1'b0;
    for (int cyc = 0; cyc < 3000 && n_done == 0; cyc++) begin
      @(negedge clk);
      if (int'(addressV) < BASE || int'(addressV) >= BASE + FW) bad_addr++;
      if (frame_done) n_done++;
      if (have_stall) begin
        chk("stall_hold", {29'd0, pix_data, pix_sof, pix_eol}, {29'd0, saved});
        have_stall = 1'b0;
      end
      if (k == 40) enable = 1'b0;
      pix_ready = 1'($urandom_range(0, 1));
      if (pix_valid && pix_ready) begin
        got = {pix_data, pix_sof, pix_eol};
        chk($sformatf("rand_px%0d", k), {29'd0, got}, {29'd0, exp_px(k, img1[(k / 16) % FW])});
        if (pix_eol) n_eol++;
        if (pix_sof) n_sof++;
        k++;
      end else if (pix_valid) begin
        saved = {pix_data, pix_sof, pix_eol};
        have_stall = 1'b1;
      end
    end
    chk("rand_px_count", k, NPIX);
    chk("rand_eol_count", n_eol, LNS);
    chk("rand_sof_count", n_sof, 1);
    chk("rand_done_count", n_done, 1);
    chk("rand_addr_range", bad_addr, 0);
    chk("stop_idle_valid", 32'(pix_valid), 0);
    chk("stop_idle_addr", 32'(addressV), BASE);
    extra_done = 0; stopped = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (frame_done) extra_done++;
      if (pix_valid) stopped = 1'b0;
    end
    chk("stop_no_extra_done", extra_done, 0);
    chk("stop_stays_idle", 32'(stopped), 1);

    // Two back-to-back frames; word 0 is rewritten after capture, then reset mid-frame 2.
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < FW; i++) begin ram[i] = 16'($urandom); img1[i] = ram[i]; end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    k = 0; n_done = 0; gaps = 0; started = 1'b0; mod_done = 1'b0;
    for (int cyc = 0; cyc < 1000 && rst_n; cyc++) begin
      @(negedge clk);
      if (started && !pix_valid) gaps++;
      if (pix_valid) started = 1'b1;
      if (frame_done) begin
        n_done++;
        chk("gapless_done_pos", k, NPIX);
        chk("gapless_sof", 32'(pix_sof), 1);
      end
      if (k == 20 && !mod_done) begin
        ram[0] = ~ram[0];
        for (int i = 0; i < FW; i++) img2[i] = ram[i];
        mod_done = 1'b1;
      end
      if (pix_valid && k == NPIX + 151) begin
        rst_n = 1'b0;
      end else if (pix_valid) begin
        w = (k < NPIX) ? img1[(k / 16) % FW] : img2[((k - NPIX) / 16) % FW];
        got = {pix_data, pix_sof, pix_eol};
        chk($sformatf("gapless_px%0d", k), {29'd0, got}, {29'd0, exp_px(k % NPIX, w)});
        k++;
      end
    end
    chk("gapless_reached", k, NPIX + 151);
    chk("gapless_no_gap", gaps, 0);
    chk("gapless_done_count", n_done, 1);

    @(negedge clk);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data", 32'(pix_data), 0);
    chk("rst_sof", 32'(pix_sof), 0);
    chk("rst_eol", 32'(pix_eol), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_addr", 32'(addressV), BASE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_prime_valid", 32'(pix_valid), 0);
    @(negedge clk);
    chk("restart_run_valid", 32'(pix_valid), 1);
    chk("restart_sof", 32'(pix_sof), 1);
    chk("restart_data", 32'(pix_data), 32'(img2[0][0]));
    extra_done = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_done) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
